// File: rtl/mac_operand_sequencer.sv
`timescale 1ns/1ps
// Operand FIFO -> credit-gated issue into `mac` -> tag-tracked capture -> result FIFO.
// Optional sticky overflow/underflow tracking: define MAC_SEQ_STICKY_FLAGS_EN.
module mac_operand_sequencer #(
    parameter int OP_DEPTH  = 4,
    parameter int RES_DEPTH = 4,
    parameter int MAC_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_a,
    input  logic [31:0]                  in_b,
    input  logic [31:0]                  in_c,
    output logic [31:0]                  mac_a,
    output logic [31:0]                  mac_b,
    output logic [31:0]                  mac_c,
    input  logic [31:0]                  mac_ieee,
    input  logic                         mac_ovf,
    input  logic                         mac_unf,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [31:0]                  res_data,
    output logic                         res_ovf,
    output logic                         res_unf,
    output logic [$clog2(RES_DEPTH):0]   in_flight,
    input  logic                         sticky_clr,
    output logic                         sticky_ovf,
    output logic                         sticky_unf
);

    localparam int OP_AW  = $clog2(OP_DEPTH);
    localparam int OP_CW  = OP_AW + 1;
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int RES_CW = RES_AW + 1;
    localparam int OP_W   = 96;
    localparam int RES_W  = 34;

    // Operand FIFO
    logic [OP_W-1:0]   op_mem_reg [OP_DEPTH];
    logic [OP_AW-1:0]  op_wr_ptr_reg, op_wr_ptr_next;
    logic [OP_AW-1:0]  op_rd_ptr_reg, op_rd_ptr_next;
    logic [OP_CW-1:0]  op_count_reg, op_count_next;
    logic [OP_W-1:0]   op_head;

    // Issue registers and latency tracking
    logic [31:0]       mac_a_reg, mac_a_next;
    logic [31:0]       mac_b_reg, mac_b_next;
    logic [31:0]       mac_c_reg, mac_c_next;
    logic [MAC_LAT:0]  tag_reg, tag_next;
    logic [RES_CW-1:0] in_flight_reg, in_flight_next;

    // Result FIFO: {data, ovf, unf} per entry
    logic [RES_DEPTH-1:0][RES_W-1:0] res_mem_reg, res_mem_next;
    logic [RES_AW-1:0] res_wr_ptr_reg, res_wr_ptr_next;
    logic [RES_AW-1:0] res_rd_ptr_reg, res_rd_ptr_next;
    logic [RES_CW-1:0] res_count_reg, res_count_next;
    logic [RES_W-1:0]  res_head;

    logic op_push;
    logic issue;
    logic capture;
    logic res_pop;
    logic credit_ok;

    assign in_ready  = op_count_reg < OP_CW'(OP_DEPTH);
    assign op_push   = in_valid && in_ready;
    // Every issued triplet reserves a result slot until it is popped, so a capture always fits.
    assign credit_ok = ({1'b0, in_flight_reg} + {1'b0, res_count_reg}) < (RES_CW + 1)'(RES_DEPTH);
    assign issue     = (op_count_reg != '0) && credit_ok;
    assign capture   = tag_reg[MAC_LAT];
    assign res_valid = res_count_reg != '0;
    assign res_pop   = res_valid && res_ready;
    assign op_head   = op_mem_reg[op_rd_ptr_reg];
    assign res_head  = res_mem_reg[res_rd_ptr_reg];

    // Operand storage has no reset: contents are only observed through the issue registers.
    always_ff @(posedge clk) begin
        if (op_push) begin
            op_mem_reg[op_wr_ptr_reg] <= {in_a, in_b, in_c};
        end
    end

    generate
        for (genvar gi = 0; gi < RES_DEPTH; gi++) begin : g_res_entry
            assign res_mem_next[gi] = (capture && (res_wr_ptr_reg == RES_AW'(gi)))
                                    ? {mac_ieee, mac_ovf, mac_unf}
                                    : res_mem_reg[gi];
        end
    endgenerate

    always_comb begin
        op_wr_ptr_next  = op_wr_ptr_reg;
        op_rd_ptr_next  = op_rd_ptr_reg;
        op_count_next   = op_count_reg;
        mac_a_next      = mac_a_reg;
        mac_b_next      = mac_b_reg;
        mac_c_next      = mac_c_reg;
        tag_next        = {tag_reg[MAC_LAT-1:0], issue};
        in_flight_next  = in_flight_reg;
        res_wr_ptr_next = res_wr_ptr_reg;
        res_rd_ptr_next = res_rd_ptr_reg;
        res_count_next  = res_count_reg;

        if (op_push) begin
            op_wr_ptr_next = op_wr_ptr_reg + OP_AW'(1);
        end
        if (issue) begin
            op_rd_ptr_next = op_rd_ptr_reg + OP_AW'(1);
            mac_a_next     = op_head[95:64];
            mac_b_next     = op_head[63:32];
            mac_c_next     = op_head[31:0];
        end
        case ({op_push, issue})
            2'b10:   op_count_next = op_count_reg + OP_CW'(1);
            2'b01:   op_count_next = op_count_reg - OP_CW'(1);
            default: op_count_next = op_count_reg;
        endcase

        case ({issue, capture})
            2'b10:   in_flight_next = in_flight_reg + RES_CW'(1);
            2'b01:   in_flight_next = in_flight_reg - RES_CW'(1);
            default: in_flight_next = in_flight_reg;
        endcase

        if (capture) begin
            res_wr_ptr_next = res_wr_ptr_reg + RES_AW'(1);
        end
        if (res_pop) begin
            res_rd_ptr_next = res_rd_ptr_reg + RES_AW'(1);
        end
        case ({capture, res_pop})
            2'b10:   res_count_next = res_count_reg + RES_CW'(1);
            2'b01:   res_count_next = res_count_reg - RES_CW'(1);
            default: res_count_next = res_count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_ptr_reg  <= '0;
            op_rd_ptr_reg  <= '0;
            op_count_reg   <= '0;
            mac_a_reg      <= '0;
            mac_b_reg      <= '0;
            mac_c_reg      <= '0;
            tag_reg        <= '0;
            in_flight_reg  <= '0;
            res_mem_reg    <= '0;
            res_wr_ptr_reg <= '0;
            res_rd_ptr_reg <= '0;
            res_count_reg  <= '0;
        end else begin
            op_wr_ptr_reg  <= op_wr_ptr_next;
            op_rd_ptr_reg  <= op_rd_ptr_next;
            op_count_reg   <= op_count_next;
            mac_a_reg      <= mac_a_next;
            mac_b_reg      <= mac_b_next;
            mac_c_reg      <= mac_c_next;
            tag_reg        <= tag_next;
            in_flight_reg  <= in_flight_next;
            res_mem_reg    <= res_mem_next;
            res_wr_ptr_reg <= res_wr_ptr_next;
            res_rd_ptr_reg <= res_rd_ptr_next;
            res_count_reg  <= res_count_next;
        end
    end

    assign mac_a     = mac_a_reg;
    assign mac_b     = mac_b_reg;
    assign mac_c     = mac_c_reg;
    assign res_data  = res_head[33:2];
    assign res_ovf   = res_head[1];
    assign res_unf   = res_head[0];
    assign in_flight = in_flight_reg;

`ifdef MAC_SEQ_STICKY_FLAGS_EN
    logic sticky_ovf_reg;
    logic sticky_unf_reg;

    // A flagged capture wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf_reg <= 1'b0;
            sticky_unf_reg <= 1'b0;
        end else begin
            if (capture && mac_ovf) begin
                sticky_ovf_reg <= 1'b1;
            end else if (sticky_clr) begin
                sticky_ovf_reg <= 1'b0;
            end
            if (capture && mac_unf) begin
                sticky_unf_reg <= 1'b1;
            end else if (sticky_clr) begin
                sticky_unf_reg <= 1'b0;
            end
        end
    end

    assign sticky_ovf = sticky_ovf_reg;
    assign sticky_unf = sticky_unf_reg;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign sticky_ovf        = 1'b0;
    assign sticky_unf        = 1'b0;
`endif

    res_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && (res_count_reg == RES_CW'(RES_DEPTH)) && !res_pop));

endmodule

// File: tb/tb_mac_operand_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for mac_operand_sequencer: behavioural mac model, table-driven
// vectors, result scoreboard and hand-written latency/credit/flag/reset sequences.
module tb_mac_operand_sequencer;

    localparam int OP_DEPTH  = 4;
    localparam int RES_DEPTH = 4;
    localparam int MAC_LAT   = 1;
    localparam int NVEC      = 16;
    localparam logic [31:0] OVF_MARK = 32'h7F7F_FFFF;
    localparam logic [31:0] UNF_MARK = 32'h0080_0000;
`ifdef MAC_SEQ_STICKY_FLAGS_EN
    localparam logic STICKY_EN = 1'b1;
`else
    localparam logic STICKY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        unf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp_data;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b, in_c;
    logic [31:0] mac_a, mac_b, mac_c;
    logic [31:0] mac_ieee;
    logic        mac_ovf, mac_unf;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_ovf, res_unf;
    logic [$clog2(RES_DEPTH):0] in_flight;
    logic        sticky_clr;
    logic        sticky_ovf, sticky_unf;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   issue_cnt    = 0;
    int   res_seen     = 0;
    logic [31:0] prev_mac_a = '0;
    logic rand_ready = 1'b0;
    res_t exp_q[$];
    vec_t vecs[NVEC];

    mac_operand_sequencer #(
        .OP_DEPTH (OP_DEPTH),
        .RES_DEPTH(RES_DEPTH),
        .MAC_LAT  (MAC_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_ieee  (mac_ieee),
        .mac_ovf   (mac_ovf),
        .mac_unf   (mac_unf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .res_unf   (res_unf),
        .in_flight (in_flight),
        .sticky_clr(sticky_clr),
        .sticky_ovf(sticky_ovf),
        .sticky_unf(sticky_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mac: known triplets give their binary32 results, anything else a bit mix.
    function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        if (a == 32'h3F8C_CCCD && b == 32'hC00C_CCCD && c == 32'h4053_3333) return 32'h3F61_47AE;
        if (a == 32'hBFC0_0000 && b == 32'h4000_0000 && c == 32'hBF00_0000) return 32'hC060_0000;
        if (a == 32'h4000_0000 && b == 32'h4040_0000 && c == 32'h3F80_0000) return 32'h40E0_0000;
        return a ^ {b[15:0], b[31:16]} ^ ~c;
    endfunction

    // Not reset on purpose: values still in the pipe after a reset must be ignored by the DUT.
    logic [33:0] mac_pipe [MAC_LAT];
    always @(posedge clk) begin
        mac_pipe[0] <= {mac_fn(mac_a, mac_b, mac_c), mac_a == OVF_MARK, mac_a == UNF_MARK};
        for (int k = 1; k < MAC_LAT; k++) mac_pipe[k] <= mac_pipe[k-1];
    end
    assign {mac_ieee, mac_ovf, mac_unf} = mac_pipe[MAC_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard pop and issue counter, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_unexpected: got 0x%0h, required no result", res_data);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sb_data", res_data, e.data);
                check("sb_flags", {res_ovf, res_unf}, {e.ovf, e.unf});
                $display("[TB] result %0d data=0x%08h ovf=%b unf=%b", res_seen, res_data,
                         res_ovf, res_unf);
                res_seen <= res_seen + 1;
            end
        end
        if (mac_a != prev_mac_a) issue_cnt <= issue_cnt + 1;
        prev_mac_a <= mac_a;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            res_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input res_t e);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send_vec(input vec_t v);
        res_t e;
        e = '{data: v.exp_data, ovf: v.exp_ovf, unf: v.exp_unf};
        send(v.a, v.b, v.c, e);
    endtask

    task automatic send_plain(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        res_t e;
        e = '{data: mac_fn(a, b, c), ovf: a == OVF_MARK, unf: a == UNF_MARK};
        send(a, b, c, e);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_flight == 0 && !res_valid) done = 1'b1;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{a: 32'h3F8C_CCCD, b: 32'hC00C_CCCD, c: 32'h4053_3333,
                    exp_data: 32'h3F61_47AE, exp_ovf: 1'b0, exp_unf: 1'b0};
        vecs[1] = '{a: 32'hBFC0_0000, b: 32'h4000_0000, c: 32'hBF00_0000,
                    exp_data: 32'hC060_0000, exp_ovf: 1'b0, exp_unf: 1'b0};
        vecs[2] = '{a: 32'h4000_0000, b: 32'h4040_0000, c: 32'h3F80_0000,
                    exp_data: 32'h40E0_0000, exp_ovf: 1'b0, exp_unf: 1'b0};
        for (int i = 3; i < NVEC; i++) begin
            vecs[i].a = (i == 5) ? OVF_MARK : (i == 9) ? UNF_MARK
                      : 32'h4010_0000 + 32'(i) * 32'h0001_3579;
            vecs[i].b = 32'hC0A0_0000 ^ 32'(i * 7);
            vecs[i].c = 32'h3E00_0000 + 32'(i);
            vecs[i].exp_data = mac_fn(vecs[i].a, vecs[i].b, vecs[i].c);
            vecs[i].exp_ovf  = (i == 5);
            vecs[i].exp_unf  = (i == 9);
        end

        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; sticky_clr = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_word", {res_data, res_ovf, res_unf}, 0);
        check("rst_mac_abc", {mac_a, mac_b, mac_c}, 0);
        check("rst_in_flight", in_flight, 0);
        check("rst_sticky", {sticky_ovf, sticky_unf}, 0);
        @(posedge clk); #1;

        // Single triplet: result visible exactly MAC_LAT+2 cycles after the accept edge.
        send_vec(vecs[0]);
        @(negedge clk); check("lat_c1_valid", res_valid, 0);
        @(negedge clk); check("lat_c2_valid", res_valid, 0);
        check("lat_issue_a", mac_a, 32'h3F8C_CCCD);
        check("lat_in_flight", in_flight, 1);
        @(negedge clk); check("lat_c3_valid", res_valid, 0);
        @(negedge clk); check("lat_c4_valid", res_valid, 1);
        check("lat_data", res_data, 32'h3F61_47AE);
        check("lat_flags", {res_ovf, res_unf}, 0);
        @(posedge clk); #1;
        drain("lat_drain");

        // Back-to-back triplets give results on consecutive cycles.
        res_ready = 1'b1;
        send_vec(vecs[1]);
        send_vec(vecs[2]);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        check("b2b_first", {res_valid, res_data}, {1'b1, 32'hC060_0000});
        @(negedge clk);
        check("b2b_second", {res_valid, res_data}, {1'b1, 32'h40E0_0000});
        @(posedge clk); #1;
        drain("b2b_drain");

        // Credit gating: consumer stalled, only RES_DEPTH triplets may issue.
        begin
            int base;
            res_ready = 1'b0;
            base = issue_cnt;
            for (int i = 0; i < 8; i++) begin
                send_plain(32'h1000_0000 + 32'(i), ~(32'h1000_0000 + 32'(i)), 32'(i) << 4);
                check("credit_in_flight_bound", (in_flight <= RES_DEPTH), 1);
            end
            @(negedge clk);
            check("credit_in_ready_full", in_ready, 0);
            step(10);
            @(negedge clk);
            check("credit_issued", issue_cnt - base, RES_DEPTH);
            check("credit_in_flight_idle", in_flight, 0);
            check("credit_res_valid", res_valid, 1);
            @(posedge clk); #1;
            drain("credit_drain");
        end

        // Overflow flag on the middle result only; sticky flag follows the build option.
        res_ready = 1'b1;
        send_plain(32'h3FC0_0000, 32'h3F00_0000, 32'h0000_0000);
        send_plain(OVF_MARK, 32'h7F00_0000, 32'h0000_0000);
        send_plain(32'h4020_0000, 32'h3E80_0000, 32'h3F80_0000);
        drain("flag_drain");
        @(negedge clk);
        check("sticky_ovf_after", sticky_ovf, STICKY_EN);
        check("sticky_unf_after", sticky_unf, 0);
        @(posedge clk); #1;
        sticky_clr = 1'b1;
        step(1);
        sticky_clr = 1'b0;
        @(negedge clk);
        check("sticky_ovf_cleared", sticky_ovf, 0);
        @(posedge clk); #1;

        // Table stream, first with a ready consumer, then with a random one.
        res_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) send_vec(vecs[i]);
        drain("table_drain");
        check("sticky_unf_stream", sticky_unf, STICKY_EN);
        rand_ready = 1'b1;
        for (int i = NVEC - 1; i >= 0; i--) send_vec(vecs[i]);
        rand_ready = 1'b0;
        step(2);
        drain("random_drain");

        // Reset with two triplets in flight and one buffered.
        res_ready = 1'b0;
        send_plain(32'h2000_0001, 32'h1, 32'h2);
        send_plain(32'h2000_0002, 32'h3, 32'h4);
        send_plain(32'h2000_0003, 32'h5, 32'h6);
        @(negedge clk);
        check("pre_rst_in_flight", in_flight, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_res_valid", res_valid, 0);
        check("post_rst_in_flight", in_flight, 0);
        check("post_rst_in_ready", in_ready, 1);
        step(6);
        @(negedge clk);
        check("late_res_valid", res_valid, 0);
        check("late_in_flight", in_flight, 0);
        check("late_sticky", {sticky_ovf, sticky_unf}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
